// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: states, opcode fields,
// datapath select codes and the packed control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_WB_R      = 4'd4,
        S_WB_I      = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WRITE = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_HALT      = 4'd12
    } state_e;

    localparam logic [1:0] CLS_R   = 2'b00;
    localparam logic [1:0] CLS_I   = 2'b01;
    localparam logic [1:0] CLS_MEM = 2'b10;
    localparam logic [1:0] CLS_CTL = 2'b11;

    localparam logic [3:0] FN_LW   = 4'b0000;
    localparam logic [3:0] FN_SW   = 4'b0001;
    localparam logic [3:0] FN_BNE  = 4'b0000;
    localparam logic [3:0] FN_JUMP = 4'b0001;
    localparam logic [3:0] FN_HALT = 4'b1111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_RFN  = 2'b01;
    localparam logic [1:0] ALUOP_SUB  = 2'b10;
    localparam logic [1:0] ALUOP_IFN  = 2'b11;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_RD2   = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_ALUR = 2'b01;
    localparam logic [1:0] PCSRC_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_word_t;

    function automatic logic is_illegal(input logic [5:0] op);
        logic [3:0] fn;
        fn = op[3:0];
        case (op[5:4])
            CLS_MEM: is_illegal = !(fn == FN_LW || fn == FN_SW);
            CLS_CTL: is_illegal = !(fn == FN_BNE || fn == FN_JUMP || fn == FN_HALT);
            default: is_illegal = 1'b0;
        endcase
    endfunction

    // Illegal opcodes fall back to FETCH.
    function automatic state_e decode_target(input logic [5:0] op);
        decode_target = S_FETCH;
        case (op[5:4])
            CLS_R:   decode_target = S_EXEC_R;
            CLS_I:   decode_target = S_EXEC_I;
            CLS_MEM: if (!is_illegal(op)) decode_target = S_MEM_ADDR;
            default: begin
                if (op[3:0] == FN_BNE)       decode_target = S_BRANCH;
                else if (op[3:0] == FN_JUMP) decode_target = S_JUMP;
                else if (op[3:0] == FN_HALT) decode_target = S_HALT;
            end
        endcase
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output table: current state to raw (ungated) datapath control word.
module ctrl_output_decode
    import ctrl_pkg::*;
(
    input  state_e     state,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.ir_write  = 1'b1;
                cw.pc_write  = 1'b1;
                cw.alu_src_b = SRCB_ONE;
                cw.alu_op    = ALUOP_ADD;
                cw.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REGB;
                cw.alu_op    = ALUOP_RFN;
            end
            S_EXEC_I: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_IFN;
            end
            S_WB_R: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b1;
            end
            S_WB_I: cw.reg_write = 1'b1;
            S_MEM_ADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                cw.mem_read = 1'b1;
                cw.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                cw.mem_write = 1'b1;
                cw.i_or_d    = 1'b1;
            end
            // PC update is qualified by not-Zero in the datapath.
            S_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_src_b     = SRCB_REGB;
                cw.alu_op        = ALUOP_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = PCSRC_ALUR;
            end
            S_JUMP: begin
                cw.pc_write  = 1'b1;
                cw.pc_source = PCSRC_IMM;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: state register, next-state, stall/reset gating.
// Optional performance counters are enabled with CTRL_PERF_COUNT_EN.
module multicycle_control_fsm
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        stall,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  state,
`ifdef CTRL_PERF_COUNT_EN
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count,
`endif
    output logic        halted,
    output logic        illegal_op
);

    state_e     state_q, state_d;
    ctrl_word_t cw_raw, cw;

    always_comb begin
        state_d = state_q;
        if (!reset) begin
            state_d = S_FETCH;
        end else if (state_q != S_HALT && !stall) begin
            case (state_q)
                S_FETCH:    state_d = S_DECODE;
                S_DECODE:   state_d = decode_target(opcode);
                S_EXEC_R:   state_d = S_WB_R;
                S_EXEC_I:   state_d = S_WB_I;
                S_MEM_ADDR: state_d = (opcode[3:0] == FN_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ: state_d = S_MEM_WB;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    ctrl_output_decode u_decode (
        .state (state_q),
        .cw    (cw_raw)
    );

    // Stall kills write strobes only; selects keep their state values.
    always_comb begin
        cw = cw_raw;
        if (stall) begin
            cw.pc_write      = 1'b0;
            cw.pc_write_cond = 1'b0;
            cw.ir_write      = 1'b0;
            cw.mem_write     = 1'b0;
            cw.reg_write     = 1'b0;
        end
        if (!reset) cw = '0;
    end

    assign PCWriteCond = cw.pc_write_cond;
    assign PCWrite     = cw.pc_write;
    assign IorD        = cw.i_or_d;
    assign MemRead     = cw.mem_read;
    assign MemWrite    = cw.mem_write;
    assign MemtoReg    = cw.mem_to_reg;
    assign IRWrite     = cw.ir_write;
    assign PCSource    = cw.pc_source;
    assign ALUOp       = cw.alu_op;
    assign ALUSrcB     = cw.alu_src_b;
    assign ALUSrcA     = cw.alu_src_a;
    assign RegWrite    = cw.reg_write;
    assign RegDst      = cw.reg_dst;

    assign state      = reset ? state_q : 4'd0;
    assign halted     = reset && (state_q == S_HALT);
    assign illegal_op = reset && !stall && (state_q == S_DECODE) && is_illegal(opcode);

`ifdef CTRL_PERF_COUNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        instr_done;

    assign instr_done = !stall && (state_q == S_WB_R || state_q == S_WB_I ||
                                   state_q == S_MEM_WB || state_q == S_MEM_WRITE ||
                                   state_q == S_BRANCH || state_q == S_JUMP);

    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (!reset) begin
            cycle_count_d = '0;
            instr_count_d = '0;
        end else begin
            if (state_q != S_HALT && !stall) cycle_count_d = cycle_count_q + 32'd1;
            if (instr_done)                  instr_count_d = instr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        cycle_count_q <= cycle_count_d;
        instr_count_q <= instr_count_d;
    end

    assign cycle_count = reset ? cycle_count_q : 32'd0;
    assign instr_count = reset ? instr_count_q : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each driven cycle pushes its hand-derived expected outputs,
// a negedge monitor pops and compares.
module tb_multicycle_control_fsm;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        stall;
    logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic [3:0]  state;
    logic        halted, illegal_op;
    logic [31:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .stall(stall),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
        .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .state(state),
`ifdef CTRL_PERF_COUNT_EN
        .cycle_count(cycle_count), .instr_count(instr_count),
`endif
        .halted(halted), .illegal_op(illegal_op)
    );

`ifndef CTRL_PERF_COUNT_EN
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [15:0] cw;
        logic        hlt;
        logic        ill;
        logic [31:0] cc;
        logic [31:0] ic;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] m_cc = 0, m_ic = 0;

    localparam logic [3:0] F  = 4'd0,  D  = 4'd1,  XR = 4'd2,  XI = 4'd3;
    localparam logic [3:0] WR = 4'd4,  WI = 4'd5,  MA = 4'd6,  MR = 4'd7;
    localparam logic [3:0] MW = 4'd8,  MX = 4'd9,  BR = 4'd10, JP = 4'd11, HL = 4'd12;

    // Field order: PCWriteCond PCWrite IorD MemRead MemWrite MemtoReg IRWrite
    //              PCSource ALUOp ALUSrcB ALUSrcA RegWrite RegDst
    function automatic logic [15:0] exp_cw(input logic [3:0] st);
        case (st)
            F:  exp_cw = 16'b0_1_0_0_0_0_1_00_00_01_0_0_0;
            D:  exp_cw = 16'b0_0_0_0_0_0_0_00_00_10_0_0_0;
            XR: exp_cw = 16'b0_0_0_0_0_0_0_00_01_00_1_0_0;
            XI: exp_cw = 16'b0_0_0_0_0_0_0_00_11_10_1_0_0;
            WR: exp_cw = 16'b0_0_0_0_0_0_0_00_00_00_0_1_1;
            WI: exp_cw = 16'b0_0_0_0_0_0_0_00_00_00_0_1_0;
            MA: exp_cw = 16'b0_0_0_0_0_0_0_00_00_10_1_0_0;
            MR: exp_cw = 16'b0_0_1_1_0_0_0_00_00_00_0_0_0;
            MW: exp_cw = 16'b0_0_0_0_0_1_0_00_00_00_0_1_0;
            MX: exp_cw = 16'b0_0_1_0_1_0_0_00_00_00_0_0_0;
            BR: exp_cw = 16'b1_0_0_0_0_0_0_01_10_00_1_0_0;
            JP: exp_cw = 16'b0_1_0_0_0_0_0_10_00_00_0_0_0;
            default: exp_cw = 16'h0000;
        endcase
    endfunction

    task automatic cyc(input logic rst, input logic [5:0] op, input logic stl,
                       input logic [3:0] st, input logic ill, input string name);
        exp_t e;
        logic [15:0] w;
        reset = rst; opcode = op; stall = stl;
        w = exp_cw(st);
        if (stl) w = w & 16'b0_0_1_1_0_1_0_11_11_11_1_0_1;
        e.name = name;
        e.st   = rst ? st : 4'd0;
        e.cw   = rst ? w : 16'h0000;
        e.hlt  = rst && (st == HL);
        e.ill  = rst && ill;
        e.cc   = rst ? m_cc : 32'd0;
        e.ic   = rst ? m_ic : 32'd0;
        q.push_back(e);
        if (!rst) begin
            m_cc = 0; m_ic = 0;
        end else begin
            if (st != HL && !stl) m_cc = m_cc + 1;
            if (!stl && (st == WR || st == WI || st == MW || st == MX || st == BR || st == JP))
                m_ic = m_ic + 1;
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = q.pop_front();
            act = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};
            vectors++;
            if (act !== e.cw || state !== e.st || halted !== e.hlt || illegal_op !== e.ill
`ifdef CTRL_PERF_COUNT_EN
                || cycle_count !== e.cc || instr_count !== e.ic
`endif
               ) begin
                miscompares++;
                $display("FAIL %s: got st=%0d cw=%b hlt=%b ill=%b cc=%0d ic=%0d, want st=%0d cw=%b hlt=%b ill=%b cc=%0d ic=%0d",
                         e.name, state, act, halted, illegal_op, cycle_count, instr_count,
                         e.st, e.cw, e.hlt, e.ill, e.cc, e.ic);
            end
        end
    end

    initial begin
        reset = 1'b0; opcode = 6'd0; stall = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cyc(0, 6'h00, 0, F, 0, "reset");

        cyc(1, 6'b00_0010, 0, F,  0, "r_fetch");
        cyc(1, 6'b00_0010, 0, D,  0, "r_decode");
        cyc(1, 6'b00_0010, 0, XR, 0, "r_exec");
        cyc(1, 6'b00_0010, 0, WR, 0, "r_wb");

        cyc(1, 6'b10_0000, 0, F,  0, "lw_fetch");
        cyc(1, 6'b10_0000, 0, D,  0, "lw_decode");
        cyc(1, 6'b10_0000, 0, MA, 0, "lw_addr");
        cyc(1, 6'b10_0000, 0, MR, 0, "lw_read");
        cyc(1, 6'b10_0000, 0, MW, 0, "lw_wb");

        cyc(1, 6'b10_0001, 0, F,  0, "sw_fetch");
        cyc(1, 6'b10_0001, 0, D,  0, "sw_decode");
        cyc(1, 6'b10_0001, 0, MA, 0, "sw_addr");
        cyc(1, 6'b10_0001, 0, MX, 0, "sw_write");

        cyc(1, 6'b11_0000, 0, F,  0, "bne_fetch");
        cyc(1, 6'b11_0000, 0, D,  0, "bne_decode");
        cyc(1, 6'b11_0000, 0, BR, 0, "bne_branch");
        cyc(1, 6'b11_0001, 0, F,  0, "j_fetch");
        cyc(1, 6'b11_0001, 0, D,  0, "j_decode");
        cyc(1, 6'b11_0001, 0, JP, 0, "j_jump");

        cyc(1, 6'b11_0101, 0, F,  0, "ill_fetch");
        cyc(1, 6'b11_0101, 0, D,  1, "ill_decode");
        cyc(1, 6'b10_0111, 0, F,  0, "ill2_fetch");
        cyc(1, 6'b10_0111, 1, D,  0, "ill2_decode_stalled");
        cyc(1, 6'b10_0111, 0, D,  1, "ill2_decode");

        cyc(1, 6'b00_0010, 1, F,  0, "st_fetch_s1");
        cyc(1, 6'b00_0010, 1, F,  0, "st_fetch_s2");
        cyc(1, 6'b00_0010, 0, F,  0, "st_fetch");
        cyc(1, 6'b00_0010, 0, D,  0, "st_decode");
        cyc(1, 6'b00_0010, 0, XR, 0, "st_exec");
        cyc(1, 6'b00_0010, 1, WR, 0, "st_wb_s1");
        cyc(1, 6'b00_0010, 1, WR, 0, "st_wb_s2");
        cyc(1, 6'b00_0010, 0, WR, 0, "st_wb");

        cyc(1, 6'b01_0011, 0, F,  0, "i_fetch");
        cyc(1, 6'b01_0011, 0, D,  0, "i_decode");
        cyc(1, 6'b01_0011, 0, XI, 0, "i_exec");
        cyc(1, 6'b01_0011, 0, WI, 0, "i_wb");

        cyc(1, 6'b00_0001, 0, F,  0, "abort_fetch");
        cyc(1, 6'b00_0001, 0, D,  0, "abort_decode");
        cyc(1, 6'b00_0001, 0, XR, 0, "abort_exec");
        cyc(0, 6'b00_0001, 0, F,  0, "abort_reset");

        cyc(1, 6'b11_1111, 0, F,  0, "h_fetch");
        cyc(1, 6'b11_1111, 0, D,  0, "h_decode");
        for (int i = 0; i < 10; i++) cyc(1, 6'b00_0000, logic'(i[0]), HL, 0, "h_halt");
        cyc(0, 6'b00_0000, 0, F,  0, "h_reset");
        cyc(1, 6'b00_0000, 0, F,  0, "h_refetch");

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
